mio_arbiter: RTL

MIO_ARBITER -- requirements
Module: mio_arbiter

---
 rtl/mio_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mio_arbiter.sv
// Two-port round-robin arbiter sharing one memory bus between CPU and DMA.
// Each grant runs until mem_ack or a 16-cycle timeout, then pulses ready.
module mio_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_DMA = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      cur;
    state_t      nxt;
    logic        last_dma;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  cnt;
    logic        err;
    logic        pick_cpu;
    logic        pick_dma;
    logic        granted;

    // On a tie the port that did not win last time gets the bus.
    always_comb begin
        pick_cpu = cpu_req && (!dma_req || last_dma);
        pick_dma = dma_req && !pick_cpu;
        granted  = (cur == GNT_CPU) || (cur == GNT_DMA);
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE: begin
                if (pick_cpu)
                    nxt = GNT_CPU;
                else if (pick_dma)
                    nxt = GNT_DMA;
            end
            GNT_CPU,
            GNT_DMA: begin
                if (mem_ack || cnt == 4'hf)
                    nxt = DONE;
            end
            DONE: nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = granted;
        mem_we    = granted ? lat_we : 1'b0;
        mem_addr  = granted ? lat_addr : 32'd0;
        mem_wdata = granted ? lat_wdata : 32'd0;
        cpu_ready = (cur == DONE) && !last_dma;
        dma_ready = (cur == DONE) && last_dma;
        bus_err   = (cur == DONE) && err;
        state     = cur;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= IDLE;
            last_dma  <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            cnt       <= 4'd0;
            err       <= 1'b0;
            cpu_rdata <= 32'd0;
            dma_rdata <= 32'd0;
        end else begin
            cur <= nxt;
            if (cur == IDLE) begin
                if (pick_cpu) begin
                    lat_we    <= cpu_we;
                    lat_addr  <= cpu_addr;
                    lat_wdata <= cpu_wdata;
                    last_dma  <= 1'b0;
                    cnt       <= 4'd0;
                    err       <= 1'b0;
                end else if (pick_dma) begin
                    lat_we    <= dma_we;
                    lat_addr  <= dma_addr;
                    lat_wdata <= dma_wdata;
                    last_dma  <= 1'b1;
                    cnt       <= 4'd0;
                    err       <= 1'b0;
                end
            end else if (granted) begin
                // Ack beats a timeout landing on the same edge.
                if (mem_ack) begin
                    if (!lat_we) begin
                        if (cur == GNT_CPU)
                            cpu_rdata <= mem_rdata;
                        else
                            dma_rdata <= mem_rdata;
                    end
                end else if (cnt == 4'hf) begin
                    err <= 1'b1;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule
